// File: rtl/mem_arbiter_pkg.sv
// Shared constants, size/state encodings and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned BUS_WIDTH       = 32;
  localparam int unsigned MEM_VECTOR_SIZE = 256;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RESP_IF = 2'b01,
    RESP_LS = 2'b10
  } arb_state_e;

  // Reserved size 11 reports 4 bytes; it is rejected by the alignment/size check anyway.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      BYTE:      return 3'd1;
      HALF_WORD: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if #(
  parameter int unsigned BUS_WIDTH = mem_arbiter_pkg::BUS_WIDTH
);
  logic                 if_req;
  logic [BUS_WIDTH-1:0] if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [BUS_WIDTH-1:0] if_rdata;
  logic                 if_err;

  logic                 ls_req;
  logic [BUS_WIDTH-1:0] ls_addr;
  logic [BUS_WIDTH-1:0] ls_wdata;
  logic                 ls_wr_en;
  logic [1:0]           ls_size;
  logic                 ls_sz_ex;
  logic                 ls_gnt;
  logic                 ls_rvalid;
  logic [BUS_WIDTH-1:0] ls_rdata;
  logic                 ls_err;

  logic [BUS_WIDTH-1:0] mem_address;
  logic [BUS_WIDTH-1:0] mem_data_in;
  logic                 mem_wr_en;
  logic [1:0]           mem_size;
  logic                 mem_sz_ex;
  logic [BUS_WIDTH-1:0] mem_data_out;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_addr, ls_wdata, ls_wr_en, ls_size, ls_sz_ex,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
    input  mem_data_out
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_addr, ls_wdata, ls_wr_en, ls_size, ls_sz_ex,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
    output mem_data_out
  );
endinterface

// File: rtl/mem_arbiter_access_check.sv
// Combinational access fault: out of range, misaligned, or reserved size encoding.
module mem_access_check
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 256
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  output logic                  fault
);

  logic [ADDR_WIDTH:0] end_addr;
  logic                misaligned;

  always_comb begin
    // One extra bit so addresses near the top of the space cannot wrap past the limit.
    end_addr   = {1'b0, addr} + (ADDR_WIDTH+1)'(access_bytes(size));
    misaligned = 1'b0;
    if (size == HALF_WORD) begin
      misaligned = addr[0];
    end else if (size == WORD) begin
      misaligned = |addr[1:0];
    end
    fault = (size == 2'b11) || misaligned || (end_addr > (ADDR_WIDTH+1)'(MEM_SIZE));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one-cycle response.
module mem_arbiter
  import mem_arbiter_pkg::arb_state_e, mem_arbiter_pkg::IDLE, mem_arbiter_pkg::RESP_IF,
         mem_arbiter_pkg::RESP_LS, mem_arbiter_pkg::WORD;
#(
  parameter int unsigned BUS_WIDTH       = mem_arbiter_pkg::BUS_WIDTH,
  parameter int unsigned MEM_VECTOR_SIZE = mem_arbiter_pkg::MEM_VECTOR_SIZE
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e           state_q, state_d;
  logic                 last_ls_q, last_ls_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 if_gnt, ls_gnt, any_gnt, fault;
  logic                 if_resp, ls_resp;
  logic [BUS_WIDTH-1:0] sel_addr;
  logic [1:0]           sel_size;

  // On contention the requester not granted last wins; last_ls_q resets to 1 so fetch wins first.
  always_comb begin
    if_gnt   = !rst && bus.if_req && (!bus.ls_req || last_ls_q);
    ls_gnt   = !rst && bus.ls_req && (!bus.if_req || !last_ls_q);
    any_gnt  = if_gnt || ls_gnt;
    sel_addr = if_gnt ? bus.if_addr : bus.ls_addr;
    sel_size = if_gnt ? WORD : bus.ls_size;
  end

  mem_access_check #(
    .ADDR_WIDTH (BUS_WIDTH),
    .MEM_SIZE   (MEM_VECTOR_SIZE)
  ) u_access_check (
    .addr  (sel_addr),
    .size  (sel_size),
    .fault (fault)
  );

  always_comb begin
    bus.mem_address = '0;
    bus.mem_data_in = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_size    = '0;
    bus.mem_sz_ex   = 1'b0;
    if (if_gnt) begin
      bus.mem_address = bus.if_addr;
      bus.mem_size    = WORD;
    end else if (ls_gnt) begin
      bus.mem_address = bus.ls_addr;
      bus.mem_data_in = bus.ls_wdata;
      bus.mem_wr_en   = bus.ls_wr_en && !fault;
      bus.mem_size    = bus.ls_size;
      bus.mem_sz_ex   = bus.ls_sz_ex;
    end
  end

  // Next state depends only on this cycle's grant, which allows back-to-back grants.
  always_comb begin
    state_d   = IDLE;
    last_ls_d = last_ls_q;
    rdata_d   = '0;
    err_d     = 1'b0;
    if (if_gnt) begin
      state_d   = RESP_IF;
      last_ls_d = 1'b0;
    end else if (ls_gnt) begin
      state_d   = RESP_LS;
      last_ls_d = 1'b1;
    end
    if (any_gnt) begin
      err_d = fault;
      if (!fault && !(ls_gnt && bus.ls_wr_en)) begin
        rdata_d = bus.mem_data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_ls_q <= 1'b1;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_ls_q <= last_ls_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Responses are masked while rst is high so a pending one never surfaces.
  always_comb begin
    if_resp       = !rst && (state_q == RESP_IF);
    ls_resp       = !rst && (state_q == RESP_LS);
    bus.if_gnt    = if_gnt;
    bus.ls_gnt    = ls_gnt;
    bus.if_rvalid = if_resp;
    bus.ls_rvalid = ls_resp;
    bus.if_rdata  = if_resp ? rdata_q : '0;
    bus.ls_rdata  = ls_resp ? rdata_q : '0;
    bus.if_err    = if_resp && err_q;
    bus.ls_err    = ls_resp && err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-array memory, round-robin grant model, response queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.BUS_WIDTH(32)) bus ();

  mem_arbiter #(
    .BUS_WIDTH       (32),
    .MEM_VECTOR_SIZE (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    bit          err;
  } resp_t;

  resp_t       sb[$];
  logic [7:0]  env_mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  env_a;
  bit          last_ls_m;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic logic [31:0] extract(logic [31:0] raw, logic [1:0] size, logic sx);
    case (size)
      2'b00:   return sx ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
      2'b01:   return sx ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign env_a = bus.mem_address[7:0];
  assign bus.mem_data_out = extract({env_mem[env_a + 8'd3], env_mem[env_a + 8'd2],
                                     env_mem[env_a + 8'd1], env_mem[env_a]},
                                    bus.mem_size, bus.mem_sz_ex);

  function automatic int unsigned nbytes(logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_raw(logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
  endfunction

  function automatic bit ref_fault(logic [31:0] addr, logic [1:0] sz);
    if (sz == 2'b11) return 1'b1;
    if ({1'b0, addr} + 33'(nbytes(sz)) > 33'd256) return 1'b1;
    if (sz == 2'b01 && addr[0]) return 1'b1;
    if (sz == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ref_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    for (int unsigned i = 0; i < nbytes(sz); i++) ref_mem[8'(a[7:0] + i)] = d[8*i +: 8];
  endfunction

  function automatic void env_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    for (int unsigned i = 0; i < nbytes(sz); i++) env_mem[8'(a[7:0] + i)] = d[8*i +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic req_if(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic req_ls(input logic [31:0] a, input logic [31:0] d, input logic wr,
                        input logic [1:0] sz, input logic sx);
    bus.ls_req   = 1'b1;
    bus.ls_addr  = a;
    bus.ls_wdata = d;
    bus.ls_wr_en = wr;
    bus.ls_size  = sz;
    bus.ls_sz_ex = sx;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.ls_wr_en = 1'b0; bus.ls_size = 2'b00; bus.ls_sz_ex = 1'b0;
  endtask

  // One cycle: check responses due now, predict/check this cycle's grant, then advance.
  task automatic step(output logic obs_if, output logic obs_ls);
    resp_t       e;
    bit          g_if, g_ls, flt;
    logic [31:0] a;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      last_ls_m = 1'b1;
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_ls_rdata", bus.ls_rdata, 32'h0);
      check("rst_errs", 32'({bus.if_err, bus.ls_err}), 32'h0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("if_rvalid", 32'(bus.if_rvalid), 32'(!e.is_ls));
      check("ls_rvalid", 32'(bus.ls_rvalid), 32'(e.is_ls));
      if (e.is_ls) begin
        check("ls_rdata", bus.ls_rdata, e.data);
        check("ls_err", 32'(bus.ls_err), 32'(e.err));
      end else begin
        check("if_rdata", bus.if_rdata, e.data);
        check("if_err", 32'(bus.if_err), 32'(e.err));
      end
    end else begin
      check("idle_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'h0);
    end

    g_if = !rst && bus.if_req && (!bus.ls_req || last_ls_m);
    g_ls = !rst && bus.ls_req && !(bus.if_req && last_ls_m);
    check("if_gnt", 32'(bus.if_gnt), 32'(g_if));
    check("ls_gnt", 32'(bus.ls_gnt), 32'(g_ls));
    if (g_if) begin
      a   = bus.if_addr;
      flt = ref_fault(a, 2'b10);
      check("if_mem_addr", bus.mem_address, a);
      check("if_mem_ctl", 32'({bus.mem_wr_en, bus.mem_size, bus.mem_sz_ex}), 32'b0100);
      sb.push_back('{is_ls: 1'b0, data: flt ? 32'h0 : ref_raw(a), err: flt});
      last_ls_m = 1'b0;
    end else if (g_ls) begin
      a   = bus.ls_addr;
      flt = ref_fault(a, bus.ls_size);
      check("ls_mem_addr", bus.mem_address, a);
      check("ls_mem_wr_en", 32'(bus.mem_wr_en), 32'(bus.ls_wr_en && !flt));
      if (bus.ls_wr_en) begin
        sb.push_back('{is_ls: 1'b1, data: 32'h0, err: flt});
        if (!flt) ref_store(a, bus.ls_wdata, bus.ls_size);
      end else begin
        sb.push_back('{is_ls: 1'b1, err: flt,
                       data: flt ? 32'h0 : extract(ref_raw(a), bus.ls_size, bus.ls_sz_ex)});
      end
      last_ls_m = 1'b1;
    end else begin
      check("nogrant_mem", 32'({bus.mem_address, bus.mem_wr_en} != 33'h0), 32'h0);
    end
    if (bus.mem_wr_en) env_store(bus.mem_address, bus.mem_data_in, bus.mem_size);
    obs_if = bus.if_gnt;
    obs_ls = bus.ls_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic oi, ol;
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    step(oi, ol);
    step(oi, ol);
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    logic        oi, ol;
    logic [31:0] if_a, ls_a;
    logic [1:0]  sz;
    int unsigned w_if, w_ls, r;
    bit          pend_if, pend_ls;

    rst = 1'b1;
    last_ls_m = 1'b1;
    idle_inputs();
    for (int unsigned i = 0; i < 256; i++) begin
      env_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    env_store(32'h10, 32'hDEADBEEF, 2'b10);
    ref_store(32'h10, 32'hDEADBEEF, 2'b10);
    do_reset();

    // Single fetch of the DEADBEEF word.
    req_if(32'h10); step(oi, ol);
    check("single_if_gnt", 32'(oi), 32'h1);
    idle_inputs(); step(oi, ol);
    step(oi, ol);

    // Reset right after a grant drops the response; fetch wins the next contention.
    req_if(32'h14); step(oi, ol);
    idle_inputs(); rst = 1'b1; step(oi, ol);
    rst = 1'b0;
    if_a = 32'h0; ls_a = 32'h40;
    req_if(if_a); req_ls(ls_a, 32'h0, 1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(oi, ol);
      check("rr_alternate", 32'({oi, ol}), (k % 2 == 0) ? 32'b10 : 32'b01);
      if (oi) begin if_a += 4; req_if(if_a); end
      if (ol) begin ls_a += 4; req_ls(ls_a, 32'h0, 1'b0, 2'b10, 1'b0); end
    end
    idle_inputs(); step(oi, ol);

    // Store/load with byte extraction and sign extension.
    req_ls(32'h20, 32'h12345678, 1'b1, 2'b10, 1'b0); step(oi, ol);
    req_ls(32'h23, 32'h0, 1'b0, 2'b00, 1'b1);        step(oi, ol);
    req_ls(32'h24, 32'h80, 1'b1, 2'b00, 1'b0);       step(oi, ol);
    req_ls(32'h24, 32'h0, 1'b0, 2'b00, 1'b1);        step(oi, ol);
    req_ls(32'h22, 32'h0, 1'b0, 2'b01, 1'b0);        step(oi, ol);
    req_ls(32'h20, 32'h0, 1'b0, 2'b01, 1'b1);        step(oi, ol);

    // Faults and range boundaries.
    req_ls(32'h21, 32'h0, 1'b0, 2'b01, 1'b0);        step(oi, ol);
    req_ls(32'hFE, 32'h0, 1'b0, 2'b10, 1'b0);        step(oi, ol);
    req_ls(32'h00, 32'h0, 1'b0, 2'b11, 1'b0);        step(oi, ol);
    req_ls(32'hFD, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0); step(oi, ol);
    req_ls(32'hFC, 32'hA5A5A5A5, 1'b1, 2'b10, 1'b0); step(oi, ol);
    req_ls(32'hFC, 32'h0, 1'b0, 2'b10, 1'b0);        step(oi, ol);
    req_ls(32'hFF, 32'h0, 1'b0, 2'b00, 1'b1);        step(oi, ol);
    req_ls(32'hFE, 32'h0, 1'b0, 2'b01, 1'b0);        step(oi, ol);
    req_ls(32'hFF, 32'h0, 1'b0, 2'b01, 1'b0);        step(oi, ol);
    idle_inputs(); req_if(32'hFE);                   step(oi, ol);
    req_if(32'h100);                                 step(oi, ol);
    idle_inputs();                                   step(oi, ol);

    // Random traffic; each requester holds its fields until granted.
    pend_if = 1'b0; pend_ls = 1'b0; w_if = 0; w_ls = 0;
    for (int n = 0; n < 300; n++) begin
      if (!pend_if && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 15);
        if_a = (r == 0) ? 32'($urandom_range(0, 259)) : {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        req_if(if_a);
        pend_if = 1'b1;
      end
      if (!pend_ls && $urandom_range(0, 3) != 0) begin
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        ls_a = 32'($urandom_range(0, 259));
        if ($urandom_range(0, 4) != 0) ls_a = ls_a & ~32'(nbytes(sz) - 1);
        req_ls(ls_a, $urandom, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)));
        pend_ls = 1'b1;
      end
      step(oi, ol);
      if (oi) begin
        check("if_wait_bound", 32'(w_if > 2), 32'h0);
        pend_if = 1'b0; w_if = 0; bus.if_req = 1'b0;
      end else if (pend_if) w_if++;
      if (ol) begin
        check("ls_wait_bound", 32'(w_ls > 2), 32'h0);
        pend_ls = 1'b0; w_ls = 0; bus.ls_req = 1'b0;
      end else if (pend_ls) w_ls++;
    end
    idle_inputs();
    step(oi, ol);
    step(oi, ol);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter MEM_VECTOR_SIZE, default 256, memory size in bytes.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have: if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_gnt  out  1  fetch accepted; if_rvalid  out  1  fetch response valid; if_rdata  out  32  fetched word; if_err  out  1  fetch fault.
REQ-005 SHALL have: ls_req  in  1  load/store request; ls_addr  in  32  byte address; ls_wdata  in  32  store data; ls_wr_en  in  1  1=store; ls_size  in  2  00 byte, 01 half, 10 word; ls_sz_ex  in  1  1=sign-extend load; ls_gnt  out  1  accepted; ls_rvalid  out  1  response valid; ls_rdata  out  32  load data; ls_err  out  1  fault.
REQ-006 SHALL have memory-side: mem_address  out  32; mem_data_in  out  32; mem_wr_en  out  1; mem_size  out  2; mem_sz_ex  out  1; mem_data_out  in  32  combinational read data.

Function
REQ-007 SHALL grant at most one requester per cycle; gnt is combinational from req, state and last-grant flag.
REQ-008 SHALL arbitrate round-robin: if only one requests, grant it; if both, grant the one not granted most recently.
REQ-009 SHALL update last-grant flag only on a cycle with a grant.
REQ-010 Requesters SHALL hold req and all request fields stable until gnt; arbiter SHALL sample fields only in the grant cycle.
REQ-011 SHALL drive memory port from the granted requester in the grant cycle; fetch forces mem_size=10, mem_sz_ex=0, mem_wr_en=0.
REQ-012 SHALL drive mem_wr_en=0 and mem_address=0 in any cycle without a valid grant.
REQ-013 SHALL register mem_data_out at the grant-cycle edge; rvalid and rdata of the granted port SHALL assert exactly one cycle after gnt (latency 1), for one cycle.
REQ-014 Store response: rvalid pulses one cycle after gnt with rdata=0.
REQ-015 SHALL flag fault when address+access_bytes > MEM_VECTOR_SIZE, or address not aligned to access size (half: bit0; word: bits1:0), or ls_size=11.
REQ-016 On fault: gnt still asserts, mem_wr_en stays 0, next cycle rvalid=1, err=1, rdata=0.
REQ-017 SHALL sustain back-to-back grants every cycle; responses SHALL keep grant order.
REQ-018 State machine: IDLE (no response pending), RESP_IF, RESP_LS (response due this cycle); next state from the current-cycle grant, independent of current state.
REQ-019 Waiting requester under contention SHALL be granted within 2 cycles.

Reset
REQ-020 On rst: state IDLE, last-grant flag = LS (fetch wins first contention), all gnt/rvalid/err=0, rdata=0, mem_wr_en=0.
REQ-021 rst asserted mid-operation SHALL drop any pending response; no rvalid after reset deasserts until a new grant.
REQ-022 SHALL issue no grant in a cycle where rst=1.

Structure
REQ-023 Shared package SHALL hold BUS_WIDTH, MEM_VECTOR_SIZE, size encodings (BYTE 00, HALF_WORD 01, WORD 10) and state encodings.
REQ-024 One sub-module, mem_access_check, SHALL compute fault from address, size and MEM_VECTOR_SIZE combinationally.

Verification
REQ-025 Only if_req, if_addr=0x10, mem word 0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xDEADBEEF.
REQ-026 Both requesting continuously after reset -> grants alternate IF, LS, IF, LS; responses in grant order.
REQ-027 ls store word 0x12345678 at 0x20, then ls load byte sz_ex=1 at 0x23 -> rdata=0x00000012; store byte 0x80 at 0x24, load byte sz_ex=1 -> 0xFFFFFF80.
REQ-028 ls load half at 0x21 or word at 0xFE -> gnt, mem_wr_en=0, next cycle ls_rvalid=1, ls_err=1, rdata=0.
REQ-029 rst asserted in cycle after a grant -> no rvalid; fetch wins first contention after reset.
